// File: rtl/timer_intr_ctrl.sv
// Machine-mode timer/external interrupt source: 64-bit mtime/mtimecmp, ext IRQ sync + edge detect, one-shot pulses gated by mret.
// Optional: define TIMER_PRESCALER_EN for the CTRL[15:8] tick prescaler.
module timer_intr_ctrl #(
    parameter int DW    = 32,
    parameter int ADDRW = 5
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [ADDRW-1:0] addr_i,
    input  logic             we_i,
    input  logic             re_i,
    input  logic [DW-1:0]    data_i,
    output logic [DW-1:0]    data_o,
    input  logic             ext_irq_i,
    input  logic             is_mret_i,
    output logic             t_intr_o,
    output logic             e_intr_o
);
    typedef enum logic [1:0] {IDLE = 2'd0, FIRE_T = 2'd1, FIRE_E = 2'd2, WAIT = 2'd3} state_t;

    localparam logic [ADDRW-1:0] A_MTIME_LO = ADDRW'(32'h00);
    localparam logic [ADDRW-1:0] A_MTIME_HI = ADDRW'(32'h04);
    localparam logic [ADDRW-1:0] A_CMP_LO   = ADDRW'(32'h08);
    localparam logic [ADDRW-1:0] A_CMP_HI   = ADDRW'(32'h0C);
    localparam logic [ADDRW-1:0] A_CTRL     = ADDRW'(32'h10);
    localparam logic [ADDRW-1:0] A_STATUS   = ADDRW'(32'h14);

    logic [63:0] mtime, mtimecmp;
    logic        en, tie, eie;
    logic        e_pend, svc_ext;
    logic        sync1, sync2, sync3;
    logic        tick, t_pend, ext_rise, e_set, e_clr;
    state_t      state;

    logic wr_mtlo, wr_mthi, wr_cmplo, wr_cmphi, wr_ctrl, wr_stat;
    assign wr_mtlo  = we_i && (addr_i == A_MTIME_LO);
    assign wr_mthi  = we_i && (addr_i == A_MTIME_HI);
    assign wr_cmplo = we_i && (addr_i == A_CMP_LO);
    assign wr_cmphi = we_i && (addr_i == A_CMP_HI);
    assign wr_ctrl  = we_i && (addr_i == A_CTRL);
    assign wr_stat  = we_i && (addr_i == A_STATUS);

`ifdef TIMER_PRESCALER_EN
    logic [7:0] presc, pcnt;
    always_ff @(posedge clk_i) begin
        if (rst_i || wr_ctrl)
            pcnt <= '0;
        else if (en)
            pcnt <= (pcnt == presc) ? 8'd0 : pcnt + 8'd1;
    end
    assign tick = en && (pcnt == presc);
`else
    assign tick = en;
`endif

    // A write to either half freezes the whole counter for that cycle
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            mtime <= '0;
        end else if (wr_mtlo || wr_mthi) begin
            if (wr_mtlo) mtime[31:0]  <= data_i;
            if (wr_mthi) mtime[63:32] <= data_i;
        end else if (tick) begin
            mtime <= mtime + 64'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            mtimecmp <= '1;
            en       <= 1'b0;
            tie      <= 1'b0;
            eie      <= 1'b0;
`ifdef TIMER_PRESCALER_EN
            presc    <= '0;
`endif
        end else begin
            if (wr_cmplo) mtimecmp[31:0]  <= data_i;
            if (wr_cmphi) mtimecmp[63:32] <= data_i;
            if (wr_ctrl) begin
                en  <= data_i[0];
                tie <= data_i[1];
                eie <= data_i[2];
`ifdef TIMER_PRESCALER_EN
                presc <= data_i[15:8];
`endif
            end
        end
    end

    assign t_pend = tie && (mtime >= mtimecmp);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            sync3 <= 1'b0;
        end else begin
            sync1 <= ext_irq_i;
            sync2 <= sync1;
            sync3 <= sync2;
        end
    end

    assign ext_rise = sync2 && !sync3;
    assign e_set    = ext_rise && eie;
    assign e_clr    = (wr_stat && data_i[1]) || (state == WAIT && is_mret_i && svc_ext);

    // Set beats clear when both land in one cycle
    always_ff @(posedge clk_i) begin
        if (rst_i)      e_pend <= 1'b0;
        else if (e_set) e_pend <= 1'b1;
        else if (e_clr) e_pend <= 1'b0;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state    <= IDLE;
            svc_ext  <= 1'b0;
            t_intr_o <= 1'b0;
            e_intr_o <= 1'b0;
        end else begin
            t_intr_o <= 1'b0;
            e_intr_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (t_pend) begin
                        state    <= FIRE_T;
                        svc_ext  <= 1'b0;
                        t_intr_o <= 1'b1;
                    end else if (e_pend) begin
                        state    <= FIRE_E;
                        svc_ext  <= 1'b1;
                        e_intr_o <= 1'b1;
                    end
                end
                FIRE_T, FIRE_E: state <= WAIT;
                WAIT: if (is_mret_i) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        data_o = '0;
        if (re_i) begin
            case (addr_i)
                A_MTIME_LO: data_o = mtime[31:0];
                A_MTIME_HI: data_o = mtime[63:32];
                A_CMP_LO:   data_o = mtimecmp[31:0];
                A_CMP_HI:   data_o = mtimecmp[63:32];
`ifdef TIMER_PRESCALER_EN
                A_CTRL:     data_o = {16'd0, presc, 5'd0, eie, tie, en};
`else
                A_CTRL:     data_o = {29'd0, eie, tie, en};
`endif
                A_STATUS:   data_o = {28'd0, state, e_pend, t_pend};
                default:    data_o = '0;
            endcase
        end
    end
endmodule

// File: tb/tb_timer_intr_ctrl.sv
// Scoreboard bench for timer_intr_ctrl: reads and interrupt pulses are queued as expectations and checked by a monitor.
module tb_timer_intr_ctrl;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [4:0]  addr = '0;
    logic        we = 1'b0, re = 1'b0;
    logic [31:0] wdata = '0;
    logic [31:0] rdata;
    logic        ext = 1'b0, mret_s = 1'b0;
    logic        t_intr, e_intr;

    timer_intr_ctrl #(.DW(32), .ADDRW(5)) dut (
        .clk_i(clk), .rst_i(rst), .addr_i(addr), .we_i(we), .re_i(re),
        .data_i(wdata), .data_o(rdata), .ext_irq_i(ext), .is_mret_i(mret_s),
        .t_intr_o(t_intr), .e_intr_o(e_intr)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { string name; logic [31:0] val; } rd_t;
    typedef struct { bit is_ext; int c; } pl_t;
    rd_t rd_q[$];
    pl_t pl_q[$];
    int  checks = 0, errors = 0;
    rd_t r;
    pl_t p;

    task automatic chk_pulse(input bit is_ext);
        checks++;
        if (pl_q.size() == 0) begin
            errors++;
            $display("FAIL pulse_unexpected: %s pulse at cycle %0d, required none", is_ext ? "e_intr" : "t_intr", cyc);
        end else begin
            p = pl_q.pop_front();
            if (p.is_ext != is_ext || p.c != cyc) begin
                errors++;
                $display("FAIL pulse: got %s at cycle %0d, required %s at cycle %0d",
                         is_ext ? "e_intr" : "t_intr", cyc, p.is_ext ? "e_intr" : "t_intr", p.c);
            end
        end
    endtask

    // Monitor: samples on the falling edge, away from the active edge
    always @(negedge clk) begin
        if (re) begin
            checks++;
            if (rd_q.size() == 0) begin
                errors++;
                $display("FAIL read_unexpected: data_o=%h, required no read", rdata);
            end else begin
                r = rd_q.pop_front();
                if (rdata !== r.val) begin
                    errors++;
                    $display("FAIL %s: got %h, required %h", r.name, rdata, r.val);
                end
            end
        end else if (!rst) begin
            checks++;
            if (rdata !== 32'd0) begin
                errors++;
                $display("FAIL data_idle: got %h with re_i=0, required 0", rdata);
            end
        end
        if (t_intr === 1'b1) chk_pulse(1'b0);
        if (e_intr === 1'b1) chk_pulse(1'b1);
    end

    task automatic step(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask
    task automatic wr(input logic [4:0] a, input logic [31:0] d);
        addr = a; wdata = d; we = 1'b1;
        step();
        we = 1'b0;
    endtask
    task automatic rd(input logic [4:0] a, input logic [31:0] e, input string nm);
        rd_q.push_back('{name: nm, val: e});
        addr = a; re = 1'b1;
        step();
        re = 1'b0;
    endtask
    task automatic do_mret();
        mret_s = 1'b1;
        step();
        mret_s = 1'b0;
    endtask
    task automatic exp_pulse(input bit is_ext, input int c);
        pl_q.push_back('{is_ext: is_ext, c: c});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, required finish");
        $fatal(1);
    end

    initial begin
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // reset values, unmapped offset, quiet period
        rd(5'h00, 32'h0, "rst_mtime_lo");
        rd(5'h04, 32'h0, "rst_mtime_hi");
        rd(5'h08, 32'hFFFF_FFFF, "rst_cmp_lo");
        rd(5'h0C, 32'hFFFF_FFFF, "rst_cmp_hi");
        rd(5'h10, 32'h0, "rst_ctrl");
        rd(5'h14, 32'h0, "rst_status");
        rd(5'h18, 32'h0, "unmapped");
        step(100);

        // low-to-high carry: two increments from 0xFFFFFFFE
        wr(5'h00, 32'hFFFF_FFFE);
        wr(5'h04, 32'h0);
        wr(5'h10, 32'h1);
        step();
        wr(5'h10, 32'h0);
        rd(5'h00, 32'h0, "carry_lo");
        rd(5'h04, 32'h1, "carry_hi");

        // timer fire at mtime==20, hold in WAIT, re-fire after mret
        wr(5'h04, 32'h0);
        wr(5'h00, 32'h0);
        wr(5'h08, 32'd20);
        wr(5'h0C, 32'h0);
        wr(5'h10, 32'h3);
        exp_pulse(1'b0, cyc + 21);
        step(30);
        rd(5'h14, 32'hD, "timer_wait_status");
        exp_pulse(1'b0, cyc + 2);
        do_mret();
        step(4);
        wr(5'h10, 32'h0);
        do_mret();
        rd(5'h14, 32'h0, "timer_done_status");
        do_mret();
        rd(5'h14, 32'h0, "mret_idle_ignored");

        // external edge, cleared by mret; held level does not retrigger
        wr(5'h10, 32'h4);
        ext = 1'b1;
        exp_pulse(1'b1, cyc + 4);
        step(8);
        rd(5'h14, 32'hE, "ext_wait_status");
        do_mret();
        rd(5'h14, 32'h0, "ext_mret_clear");
        step(10);
        ext = 1'b0;
        step(4);

        // external edge, e_pend cleared by W1C
        ext = 1'b1;
        exp_pulse(1'b1, cyc + 4);
        step(6);
        ext = 1'b0;
        wr(5'h14, 32'h2);
        rd(5'h14, 32'hC, "ext_w1c_status");
        do_mret();
        rd(5'h14, 32'h0, "ext_w1c_idle");

        // EIE=0: edge ignored
        wr(5'h10, 32'h0);
        ext = 1'b1;
        step(6);
        ext = 1'b0;
        step(4);
        rd(5'h14, 32'h0, "eie_off_status");

        // timer and external pending together: timer first, then external
        wr(5'h00, 32'h0);
        wr(5'h04, 32'h0);
        wr(5'h08, 32'h0);
        wr(5'h0C, 32'h0);
        wr(5'h10, 32'h4);
        ext = 1'b1;
        step(2);
        wr(5'h10, 32'h6);
        exp_pulse(1'b0, cyc + 1);
        step(4);
        rd(5'h14, 32'hF, "both_wait_status");
        wr(5'h08, 32'd100);
        rd(5'h14, 32'hE, "both_cmp_moved");
        exp_pulse(1'b1, cyc + 2);
        do_mret();
        step(4);
        rd(5'h14, 32'hE, "both_ext_wait");
        do_mret();
        rd(5'h14, 32'h0, "both_done");
        ext = 1'b0;

        // prescaler field: P=3 over 8 enabled cycles
        wr(5'h10, 32'h0);
        wr(5'h00, 32'h0);
        wr(5'h04, 32'h0);
        wr(5'h10, 32'h0301);
`ifdef TIMER_PRESCALER_EN
        rd(5'h10, 32'h0301, "ctrl_presc_rb");
        step(6);
        wr(5'h10, 32'h0);
        rd(5'h00, 32'd2, "presc_mtime");
`else
        rd(5'h10, 32'h0001, "ctrl_presc_rb");
        step(6);
        wr(5'h10, 32'h0);
        rd(5'h00, 32'd8, "presc_mtime");
`endif
        rd(5'h04, 32'h0, "presc_mtime_hi");

        // reset while waiting for mret
        wr(5'h10, 32'h4);
        ext = 1'b1;
        exp_pulse(1'b1, cyc + 4);
        step(6);
        rst = 1'b1;
        step();
        rst = 1'b0;
        rd(5'h14, 32'h0, "rst_wait_status");
        rd(5'h10, 32'h0, "rst_wait_ctrl");
        rd(5'h08, 32'hFFFF_FFFF, "rst_wait_cmp");
        ext = 1'b0;
        step(5);

        checks++;
        if (pl_q.size() != 0) begin
            errors++;
            $display("FAIL pulse_missing: %0d pulses outstanding, required 0", pl_q.size());
        end
        checks++;
        if (rd_q.size() != 0) begin
            errors++;
            $display("FAIL read_missing: %0d reads outstanding, required 0", rd_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
